// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell sequenced LSB first over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       state_dbg
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid may not depend on ready, and once out_valid rises
    // sum/cout stay stable until out_ready is seen.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             sum_bit;
    logic             c_next;

    assign sum_bit = a_q[0] ^ b_q[0] ^ c_q;
    assign c_next  = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & c_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = cin;
                    s_d     = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                s_d   = {sum_bit, s_q[WIDTH-1:1]};
                c_d   = c_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // c_q here is the carry into the MSB
                    ovf_d   = c_q ^ c_next;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Gated by reset so operands offered during a reset cycle are never accepted
    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == DONE);
    assign sum       = s_q;
    assign cout      = c_q;
    assign state_dbg = state_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf       = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder with a result scoreboard.
// Define SERIAL_ADD_OVF_EN to also check the ovf output.
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic [1:0]   state_dbg;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic [W+1:0] exp_q[$];

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .state_dbg (state_dbg)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- model ----------------
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        logic [W:0] full;
        logic       v;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        v    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return {v, full};
    endfunction

    // ---------------- drivers ----------------
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input bit push_exp);
        @(negedge clk);
        check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = c;
        if (push_exp) exp_q.push_back(model(x, y, c));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits for out_valid, checks latency and result, optionally stalls, then handshakes.
    task automatic collect(input int stall);
        int lat;
        logic [W+1:0] e;
        lat = 0;
        while (!out_valid && lat < 4 * W) begin
            lat++;
            @(negedge clk);
        end
        check("latency", lat, W);
        if (!out_valid) return;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty_on_output", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        for (int i = 0; i < stall; i++) begin
            if (i == 2) begin
                in_valid = 1'b1;
                a        = 8'h11;
                b        = 8'h22;
                cin      = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b0;
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_sum", {24'd0, sum}, {24'd0, e[W-1:0]});
        end
        check("sum", {24'd0, sum}, {24'd0, e[W-1:0]});
        check("cout", {31'd0, cout}, {31'd0, e[W]});
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, e[W+1]});
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        // Reset for two cycles, offering operands that must be ignored
        @(negedge clk);
        in_valid = 1'b1;
        a        = 8'hAA;
        @(negedge clk);
        check("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_sum", {24'd0, sum}, 32'd0);
        check("reset_cout", {31'd0, cout}, 32'd0);
        check("reset_state", {30'd0, state_dbg}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("reset_ovf", {31'd0, ovf}, 32'd0);
`endif

        // Directed sums
        issue(8'h3C, 8'h05, 1'b0, 1'b1); collect(0);
        issue(8'hFF, 8'h01, 1'b0, 1'b1); collect(0);
        issue(8'hFF, 8'hFF, 1'b1, 1'b1); collect(0);
        issue(8'h7F, 8'h01, 1'b0, 1'b1); collect(0);
        issue(8'h80, 8'h80, 1'b0, 1'b1); collect(0);
        issue(8'h00, 8'h00, 1'b1, 1'b1); collect(0);

        // Backpressure with an in_valid pulse during DONE
        issue(8'h5A, 8'hA7, 1'b1, 1'b1); collect(5);
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check("no_capture_during_done", {31'd0, out_valid}, 32'd0);
        end

        // Abort mid-RUN with reset
        issue(8'h55, 8'h11, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_state", {30'd0, state_dbg}, 32'd0);
        check("abort_sum", {24'd0, sum}, 32'd0);
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check("abort_no_out_valid", {31'd0, out_valid}, 32'd0);
        end
        issue(8'h10, 8'h20, 1'b0, 1'b1); collect(0);

        // Random operands
        for (int i = 0; i < 6; i++) begin
            issue(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'b1);
            collect(i % 3);
        end

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
